// File: rtl/tomasulo_exe_mpy_q.sv
// ============================================================================
// Module   : tomasulo_exe_mpy_q
// Brief    : Parametrised multiply execution unit for the Tomasulo pipeline.
//            Valid/ready issue, LAT-stage multiplier, Q-entry in-order result
//            queue feeding the CDB, credit counter bounding in-flight work.
//            Optional macro TOMASULO_EXE_MPY_FLUSH_EN adds a flush input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tomasulo_exe_mpy_q #(
    parameter int W       = 32,
    parameter int LAT     = 5,
    parameter int Q       = 4,
    parameter int REG_W   = 5,
    parameter int TAG_W   = 4,
    parameter int ROBID_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef TOMASULO_EXE_MPY_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               iss_vld,
    output logic               iss_rdy,
    input  logic [1:0]         iss_op,
    input  logic [W-1:0]       iss_a,
    input  logic [W-1:0]       iss_b,
    input  logic [REG_W-1:0]   iss_wa,
    input  logic [TAG_W-1:0]   iss_tag,
    input  logic [ROBID_W-1:0] iss_robid,
    input  logic               cdb_gnt,
    output logic               cdb_vld_r,
    output logic [W-1:0]       cdb_wdata_r,
    output logic [REG_W-1:0]   cdb_wa_r,
    output logic [TAG_W-1:0]   cdb_tag_r,
    output logic [ROBID_W-1:0] cdb_robid_r,
    output logic               busy_r
);

    localparam int EW = W + REG_W + TAG_W + ROBID_W;
    localparam int PW = $clog2(Q);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] Q_CNT = CW'(Q);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHU  = 2'b10;

    logic flush_now;
`ifdef TOMASULO_EXE_MPY_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Credit counter and queue state
    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] qcnt, qcnt_nx;
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nx;
    logic [EW-1:0] mem [Q];
    logic [EW-1:0] head_nx;

    logic accept, pop, push, push_q;
    logic [EW-1:0] in_ent, push_ent;

    // Ready depends only on the credit count (and an active flush).
    assign iss_rdy = (cnt < Q_CNT) & ~flush_now;
    assign accept  = iss_vld & iss_rdy;
    assign pop     = cdb_vld_r & cdb_gnt & ~flush_now;
    assign push_q  = push & ~flush_now;

    // Operand extension and product selection. Extending to 2W bits is
    // equivalent to W+1-bit extension and keeps every product bit meaningful.
    logic          a_sgn, b_sgn;
    logic [2*W-1:0] a_ext, b_ext, prod;
    logic [W-1:0]   res;

    // Multiply datapath for the op presented at issue
    always_comb begin
        a_sgn = (iss_op != OP_MULHU);
        b_sgn = (iss_op == OP_MULH);
        a_ext = {{W{a_sgn & iss_a[W-1]}}, iss_a};
        b_ext = {{W{b_sgn & iss_b[W-1]}}, iss_b};
        prod  = a_ext * b_ext;
        res   = (iss_op == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
    end

    assign in_ent = {res, iss_wa, iss_tag, iss_robid};

    // The queue write itself is the last of the LAT stages, so LAT-1
    // pipeline registers sit between issue and the queue.
    generate
        if (LAT == 1) begin : g_direct
            assign push     = accept;
            assign push_ent = in_ent;
        end else begin : g_pipe
            logic [LAT-2:0] pv;
            logic [EW-1:0]  pe [LAT-1];

            // Valid bits shift toward the queue; cleared on reset/flush
            always_ff @(posedge clk) begin
                if (!rst_n || flush_now) begin
                    pv <= '0;
                end else begin
                    pv[0] <= accept;
                    for (int i = 1; i < LAT - 1; i++) begin
                        pv[i] <= pv[i-1];
                    end
                end
            end

            // Result and sideband travel alongside the valid bits
            always_ff @(posedge clk) begin
                pe[0] <= in_ent;
                for (int i = 1; i < LAT - 1; i++) begin
                    pe[i] <= pe[i-1];
                end
            end

            assign push     = pv[LAT-2];
            assign push_ent = pe[LAT-2];
        end
    endgenerate

    // Next-state for counters and the value the CDB head will present
    always_comb begin
        cnt_nx  = cnt + CW'(accept) - CW'(pop);
        qcnt_nx = qcnt + CW'(push_q) - CW'(pop);
        rd_nx   = rd_ptr + PW'(pop);
        head_nx = '0;
        if (qcnt_nx != '0) begin
            // Queue empty after this pop: the head is the entry arriving now.
            head_nx = (qcnt == CW'(pop)) ? push_ent : mem[rd_nx];
        end
    end

    // Queue storage write
    always_ff @(posedge clk) begin
        if (push_q) begin
            mem[wr_ptr] <= push_ent;
        end
    end

    // Counters, pointers and registered CDB outputs
    always_ff @(posedge clk) begin
        if (!rst_n || flush_now) begin
            cnt         <= '0;
            qcnt        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cdb_vld_r   <= 1'b0;
            cdb_wdata_r <= '0;
            cdb_wa_r    <= '0;
            cdb_tag_r   <= '0;
            cdb_robid_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            qcnt      <= qcnt_nx;
            wr_ptr    <= wr_ptr + PW'(push_q);
            rd_ptr    <= rd_nx;
            cdb_vld_r <= (qcnt_nx != '0);
            {cdb_wdata_r, cdb_wa_r, cdb_tag_r, cdb_robid_r} <= head_nx;
            busy_r    <= (cnt_nx != '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tomasulo_exe_mpy_q.sv
// ============================================================================
// Module   : tb_tomasulo_exe_mpy_q
// Brief    : Self-checking bench for tomasulo_exe_mpy_q (W=32, LAT=5, Q=4).
//            Reference model: one ordered list of accepted ops, each with the
//            cycle from which it may appear on the CDB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tomasulo_exe_mpy_q;

    localparam int W   = 32;
    localparam int LAT = 5;
    localparam int Q   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iss_vld = 1'b0;
    logic        iss_rdy;
    logic [1:0]  iss_op = '0;
    logic [31:0] iss_a = '0, iss_b = '0;
    logic [4:0]  iss_wa = '0;
    logic [3:0]  iss_tag = '0, iss_robid = '0;
    logic        cdb_gnt = 1'b0;
    logic        cdb_vld_r;
    logic [31:0] cdb_wdata_r;
    logic [4:0]  cdb_wa_r;
    logic [3:0]  cdb_tag_r, cdb_robid_r;
    logic        busy_r;
`ifdef TOMASULO_EXE_MPY_FLUSH_EN
    logic        flush = 1'b0;
`endif

    tomasulo_exe_mpy_q #(
        .W(W), .LAT(LAT), .Q(Q), .REG_W(5), .TAG_W(4), .ROBID_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef TOMASULO_EXE_MPY_FLUSH_EN
        .flush(flush),
`endif
        .iss_vld(iss_vld),
        .iss_rdy(iss_rdy),
        .iss_op(iss_op),
        .iss_a(iss_a),
        .iss_b(iss_b),
        .iss_wa(iss_wa),
        .iss_tag(iss_tag),
        .iss_robid(iss_robid),
        .cdb_gnt(cdb_gnt),
        .cdb_vld_r(cdb_vld_r),
        .cdb_wdata_r(cdb_wdata_r),
        .cdb_wa_r(cdb_wa_r),
        .cdb_tag_r(cdb_tag_r),
        .cdb_robid_r(cdb_robid_r),
        .busy_r(busy_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  wa;
        logic [3:0]  tag;
        logic [3:0]  rob;
        int          rdy;
    } ent_t;

    ent_t mq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   fl    = 1'b0;
    bit   last_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Full 64-bit product of the extended operands, high or low word picked.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (op == 2'b10) ? {32'd0, a} : {{32{a[31]}}, a};
        xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle: drive inputs, compare outputs against the model, advance model.
    task automatic step(input bit v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input logic [3:0] tag,
                        input logic [3:0] rob, input bit g);
        bit   m_vld, m_rdy;
        ent_t e;
        @(negedge clk);
        iss_vld = v; iss_op = op; iss_a = a; iss_b = b;
        iss_wa = wa; iss_tag = tag; iss_robid = rob; cdb_gnt = g;
`ifdef TOMASULO_EXE_MPY_FLUSH_EN
        flush = fl;
`endif
        m_vld = (mq.size() > 0) && (mq[0].rdy <= cyc);
        m_rdy = (mq.size() < Q) && !fl;
        chk("cdb_vld", 64'(cdb_vld_r), 64'(m_vld));
        chk("wdata", 64'(cdb_wdata_r), m_vld ? 64'(mq[0].d)   : 64'd0);
        chk("wa",    64'(cdb_wa_r),    m_vld ? 64'(mq[0].wa)  : 64'd0);
        chk("tag",   64'(cdb_tag_r),   m_vld ? 64'(mq[0].tag) : 64'd0);
        chk("robid", 64'(cdb_robid_r), m_vld ? 64'(mq[0].rob) : 64'd0);
        chk("busy",  64'(busy_r),      64'(mq.size() != 0));
        chk("rdy",   64'(iss_rdy),     64'(m_rdy));
        last_acc = v && m_rdy;
        if (fl) begin
            mq.delete();
        end else begin
            if (m_vld && g) void'(mq.pop_front());
            if (last_acc) begin
                e.d = ref_mul(op, a, b); e.wa = wa; e.tag = tag; e.rob = rob;
                e.rdy = cyc + LAT;
                mq.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit g);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 4'd0, 4'd0, g);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; iss_vld = 1'b1; cdb_gnt = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_vld", 64'(cdb_vld_r), 64'd0);
            chk("rst_busy", 64'(busy_r), 64'd0);
        end
        rst_n = 1'b1; iss_vld = 1'b0;
        mq.delete();
        chk("rst_rdy", 64'(iss_rdy), 64'd1);
    endtask

    initial begin : main
        logic [31:0] t3_exp [4];
        int          guard;
        t3_exp[0] = 32'h0000_0001; t3_exp[1] = 32'h0000_0000;
        t3_exp[2] = 32'hFFFF_FFFE; t3_exp[3] = 32'hFFFF_FFFF;

        // Reset held with an issue request pending
        do_reset(3);
        idle(2, 1'b1);

        // Single MUL, granted immediately
        step(1'b1, 2'b00, 32'd7, 32'd6, 5'd9, 4'd3, 4'd2, 1'b1);
        idle(5, 1'b1);
        chk("t2_vld",  64'(cdb_vld_r),   64'd1);
        chk("t2_data", 64'(cdb_wdata_r), 64'd42);
        chk("t2_tag",  64'(cdb_tag_r),   64'd3);
        chk("t2_wa",   64'(cdb_wa_r),    64'd9);
        chk("t2_rob",  64'(cdb_robid_r), 64'd2);
        idle(1, 1'b1);
        chk("t2_vld_off", 64'(cdb_vld_r), 64'd0);
        chk("t2_busy",    64'(busy_r),    64'd0);

        // All four modes on all-ones operands
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(i), 4'(i), 4'(i), 1'b1);
        idle(1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1, 1'b1);
            chk("t3_mode", 64'(cdb_wdata_r), 64'(t3_exp[i]));
        end
        idle(3, 1'b1);

        // Backpressure: five back-to-back issues with no grant
        for (int t = 1; t <= 4; t++)
            step(1'b1, 2'b00, 32'(t), 32'(t), 5'(t), 4'(t), 4'(t), 1'b0);
        step(1'b1, 2'b00, 32'd5, 32'd5, 5'd5, 4'd5, 4'd5, 1'b0);
        chk("t4_rdy_full", 64'(iss_rdy), 64'd0);
        guard = 0;
        do begin
            step(1'b1, 2'b00, 32'd5, 32'd5, 5'd5, 4'd5, 4'd5, 1'b1);
            guard++;
        end while (!last_acc && guard < 20);
        chk("t4_tag5_accepted", 64'(last_acc), 64'd1);
        idle(10, 1'b1);

        // Full queue, simultaneous grant and issue
        for (int t = 0; t < 4; t++)
            step(1'b1, 2'b11, pick(), pick(), 5'(t), 4'(t + 8), 4'(t), 1'b0);
        idle(6, 1'b0);
        step(1'b1, 2'b01, pick(), pick(), 5'd31, 4'd15, 4'd15, 1'b1);
        idle(10, 1'b1);

`ifdef TOMASULO_EXE_MPY_FLUSH_EN
        // Flush with two queued results and two ops in flight
        step(1'b1, 2'b00, 32'd3, 32'd3, 5'd1, 4'd1, 4'd1, 1'b0);
        step(1'b1, 2'b00, 32'd4, 32'd4, 5'd2, 4'd2, 4'd2, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 2'b00, 32'd5, 32'd5, 5'd3, 4'd3, 4'd3, 1'b0);
        step(1'b1, 2'b00, 32'd6, 32'd6, 5'd4, 4'd4, 4'd4, 1'b0);
        fl = 1'b1;
        step(1'b1, 2'b00, 32'd7, 32'd7, 5'd5, 4'd5, 4'd5, 1'b1);
        fl = 1'b0;
        idle(8, 1'b1);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, 2'($urandom), pick(), pick(),
                 5'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 9) < 6);

        // Reset with work in flight and queued; nothing must survive
        for (int i = 0; i < 6; i++)
            step(1'b1, 2'($urandom), pick(), pick(), 5'($urandom), 4'($urandom),
                 4'($urandom), 1'b0);
        do_reset(2);
        idle(10, 1'b1);

        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 9) < 8, 2'($urandom), pick(), pick(),
                 5'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 9) < 4);
        idle(12, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
